forward_history: RTL

Pipeline history register feeding the forwarding-judgment stage. Each cycle it captures the decoded fields (op1, op2, cond, op3) of the instruction leaving ID. It shifts them through three slots: cur (EX), bef (MEM) and twobef (WB), and presents all three field sets to the forwarding-judgment logic. It also inserts bubbles on flush, holds on a global stall, and raises a load-use interlock request when forwarding cannot cover a dependency.

---
 rtl/forward_history.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/forward_history.sv
`default_nettype none
// ============================================================================
// Module   : forward_history
// Purpose  : Three-slot history (cur/EX, bef/MEM, twobef/WB) of decoded
//            instruction fields for the forwarding-judgment stage. It inserts
//            bubbles on flush, holds on a global stall and, when enabled,
//            raises a load-use interlock request.
// Config   : `define FWD_HIST_LOADUSE_EN to enable load-use detection.
//            When it is undefined, lu_stall_req_o is tied low and the
//            compiler delay slot after loads is relied upon instead.
// Revision : 1.0 - initial release
// ============================================================================
module forward_history (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid_i,
    input  logic [1:0] id_op1_i,
    input  logic [2:0] id_op2_i,
    input  logic [2:0] id_cond_i,
    input  logic [3:0] id_op3_i,
    input  logic       stall_i,
    input  logic       flush_i,
    output logic [1:0] cur_op1_o,
    output logic [2:0] cur_op2_o,
    output logic [2:0] cur_cond_o,
    output logic [3:0] cur_op3_o,
    output logic [1:0] bef_op1_o,
    output logic [2:0] bef_op2_o,
    output logic [2:0] bef_cond_o,
    output logic [3:0] bef_op3_o,
    output logic [1:0] twobef_op1_o,
    output logic [2:0] twobef_op2_o,
    output logic [2:0] twobef_cond_o,
    output logic [3:0] twobef_op3_o,
    output logic       cur_valid_o,
    output logic       bef_valid_o,
    output logic       twobef_valid_o,
    output logic       lu_stall_req_o
);

    typedef struct packed {
        logic       valid;
        logic [1:0] op1;
        logic [2:0] op2;
        logic [2:0] cond;
        logic [3:0] op3;
    } slot_t;

    // Bubble encoding chosen so it never matches any forwarding producer.
    localparam slot_t C_BUBBLE = '{valid: 1'b0, op1: 2'b10, op2: 3'b111,
                                   cond: 3'b000, op3: 4'b0000};

    slot_t cur_q, bef_q, twobef_q;
    slot_t cur_d, bef_d, twobef_d;
    logic  lu_req;

`ifdef FWD_HIST_LOADUSE_EN
    logic cur_is_load;
    logic id_reads_a;
    logic id_reads_b;

    // Decode which source operands the ID instruction consumes and whether EX holds a load.
    always_comb begin
        cur_is_load = cur_q.valid && (cur_q.op1 == 2'b10) && (cur_q.op2 == 3'b000);

        id_reads_a = 1'b0;
        if (id_op1_i == 2'b01) begin
            id_reads_a = 1'b1;
        end else if (id_op1_i == 2'b11) begin
            id_reads_a = (id_op3_i <= 4'd6) || (id_op3_i == 4'd13);
        end

        id_reads_b = 1'b0;
        case (id_op1_i)
            2'b00, 2'b01: id_reads_b = 1'b1;
            2'b11:        id_reads_b = (id_op3_i <= 4'd5) ||
                                       ((id_op3_i >= 4'd8) && (id_op3_i <= 4'd11));
            default:      id_reads_b = (id_op2_i == 3'b001) || (id_op2_i == 3'b010) ||
                                       (id_op2_i == 3'b110);
        endcase

        // A flush squashes the consumer, so no interlock is needed for it.
        lu_req = id_valid_i && !flush_i && cur_is_load &&
                 ((id_reads_a && (id_op2_i  == cur_q.cond)) ||
                  (id_reads_b && (id_cond_i == cur_q.cond)));
    end
`else
    // Loads are covered by a compiler-inserted delay slot; never interlock.
    always_comb begin
        lu_req = 1'b0;
    end
`endif

    // Next-state selection: shift on advance, hold everything on stall.
    always_comb begin
        cur_d    = cur_q;
        bef_d    = bef_q;
        twobef_d = twobef_q;
        if (!stall_i) begin
            twobef_d = bef_q;
            bef_d    = cur_q;
`ifdef FWD_HIST_LOADUSE_EN
            if (flush_i || lu_req || !id_valid_i) begin
`else
            if (flush_i || !id_valid_i) begin
`endif
                cur_d = C_BUBBLE;
            end else begin
                cur_d = '{valid: 1'b1, op1: id_op1_i, op2: id_op2_i,
                          cond: id_cond_i, op3: id_op3_i};
            end
        end
    end

    // Slot registers; asynchronous reset loads bubbles into every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= C_BUBBLE;
            bef_q    <= C_BUBBLE;
            twobef_q <= C_BUBBLE;
        end else begin
            cur_q    <= cur_d;
            bef_q    <= bef_d;
            twobef_q <= twobef_d;
        end
    end

    // Outputs come straight from registers, except the interlock request.
    always_comb begin
        cur_valid_o    = cur_q.valid;
        cur_op1_o      = cur_q.op1;
        cur_op2_o      = cur_q.op2;
        cur_cond_o     = cur_q.cond;
        cur_op3_o      = cur_q.op3;
        bef_valid_o    = bef_q.valid;
        bef_op1_o      = bef_q.op1;
        bef_op2_o      = bef_q.op2;
        bef_cond_o     = bef_q.cond;
        bef_op3_o      = bef_q.op3;
        twobef_valid_o = twobef_q.valid;
        twobef_op1_o   = twobef_q.op1;
        twobef_op2_o   = twobef_q.op2;
        twobef_cond_o  = twobef_q.cond;
        twobef_op3_o   = twobef_q.op3;
        lu_stall_req_o = lu_req;
    end

endmodule
`default_nettype wire
